// File: rtl/clk_div_prog_if.sv
// Divisor configuration channel for clk_div_prog.
// Master drives a request, slave answers with a combinational ready.
interface clk_div_prog_if #(
  parameter int NCH   = 2,
  parameter int DIV_W = 8
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock-enable generator with glitch-free divisor
// updates at period boundaries, per-channel lock flags and global phase sync.
module clk_div_prog #(
  parameter int NCH          = 2,
  parameter int DIV_W        = 8,
  parameter int DEF_DIV      = 10,
  parameter int LOCK_PERIODS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  clk_div_prog_if.slave   cfg,
  input  logic            sync_i,
  output logic [NCH-1:0]  ce_o,
  output logic [NCH-1:0]  clk_o,
  output logic [NCH-1:0]  locked_o
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LK_W = $clog2(LOCK_PERIODS + 1);

  typedef logic [DIV_W-1:0] div_t;
  typedef logic [LK_W-1:0]  lk_t;

  div_t           cur_div_q  [NCH];
  div_t           cur_div_d  [NCH];
  div_t           pend_div_q [NCH];
  div_t           pend_div_d [NCH];
  div_t           cnt_q      [NCH];
  div_t           cnt_d      [NCH];
  lk_t            lock_cnt_q [NCH];
  lk_t            lock_cnt_d [NCH];
  logic [NCH-1:0] pend_vld_q, pend_vld_d;
  logic [NCH-1:0] ce_q, ce_d, clk_q, clk_d, lock_q, lock_d;
  logic [NCH-1:0] en, wrap, accept, apply;

  // Out-of-range channel indices read as ready so such requests are swallowed.
  logic [(2**CH_W)-1:0] rdy_vec;

  always_comb begin
    rdy_vec          = '1;
    rdy_vec[NCH-1:0] = ~pend_vld_q;
  end

  assign cfg.cfg_ready = rdy_vec[cfg.cfg_ch];

  always_comb begin
    en         = '0;
    wrap       = '0;
    accept     = '0;
    apply      = '0;
    pend_vld_d = '0;
    ce_d       = '0;
    clk_d      = '0;
    lock_d     = '0;
    for (int i = 0; i < NCH; i++) begin
      cur_div_d[i]  = cur_div_q[i];
      pend_div_d[i] = pend_div_q[i];
      cnt_d[i]      = cnt_q[i];
      lock_cnt_d[i] = lock_cnt_q[i];

      en[i]     = (cur_div_q[i] != '0);
      wrap[i]   = en[i] && (cnt_q[i] == cur_div_q[i] - div_t'(1));
      accept[i] = cfg.cfg_valid && !pend_vld_q[i] && (cfg.cfg_ch == CH_W'(i));
      apply[i]  = pend_vld_q[i] && (wrap[i] || sync_i || !en[i]);

      // accept and apply are exclusive: accept needs pend clear, apply needs it set
      pend_vld_d[i] = accept[i] || (pend_vld_q[i] && !apply[i]);
      if (accept[i]) pend_div_d[i] = cfg.cfg_div;

      if (apply[i]) begin
        cur_div_d[i]  = pend_div_q[i];
        cnt_d[i]      = '0;
        lock_cnt_d[i] = '0;
      end else if (!en[i] || sync_i) begin
        cnt_d[i]      = '0;
        lock_cnt_d[i] = '0;
      end else if (wrap[i]) begin
        cnt_d[i] = '0;
        if (lock_cnt_q[i] != lk_t'(LOCK_PERIODS)) lock_cnt_d[i] = lock_cnt_q[i] + lk_t'(1);
      end else begin
        cnt_d[i] = cnt_q[i] + div_t'(1);
      end

      ce_d[i]   = en[i] && (wrap[i] || sync_i);
      clk_d[i]  = (cur_div_d[i] != '0) && (cnt_d[i] < (cur_div_d[i] >> 1));
      lock_d[i] = (cur_div_d[i] != '0) && (lock_cnt_d[i] == lk_t'(LOCK_PERIODS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cur_div_q[i]  <= div_t'(DEF_DIV);
        pend_div_q[i] <= '0;
        cnt_q[i]      <= '0;
        lock_cnt_q[i] <= '0;
      end
      pend_vld_q <= '0;
      ce_q       <= '0;
      clk_q      <= '0;
      lock_q     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cur_div_q[i]  <= cur_div_d[i];
        pend_div_q[i] <= pend_div_d[i];
        cnt_q[i]      <= cnt_d[i];
        lock_cnt_q[i] <= lock_cnt_d[i];
      end
      pend_vld_q <= pend_vld_d;
      ce_q       <= ce_d;
      clk_q      <= clk_d;
      lock_q     <= lock_d;
    end
  end

  assign ce_o     = ce_q;
  assign clk_o    = clk_q;
  assign locked_o = lock_q;
endmodule
